seg7_scan_driver: RTL

- Time-multiplexed N-digit 7-segment driver; successor to the single-digit hex decoder.
- Latches a packed hex word and scans one digit at a time with a one-hot anode strobe.
- Adds leading-zero blanking, per-digit blank, blink and decimal-point control, and an anti-ghosting guard interval.
- Sits between the vending-machine datapath (price/credit/change values) and the board display pins.

---
 rtl/seg7_scan_driver_pkg.sv | 21 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment display blocks: digit width, segment bit
// positions and the lit-high hex-to-segment table.
package seg7_scan_driver_pkg;

  localparam int DIGIT_W = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Element [n] is the lit-high g..a pattern for hex value n.
  localparam logic [15:0][6:0] HEX_SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Pure combinational nibble to lit-high segment lookup, shared by display blocks.
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nibble,
  output logic [6:0]         o_seg
);

  assign o_seg = HEX_SEG_LUT[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with an anti-ghosting guard interval,
// per-digit blank/blink/dp and leading-zero blanking.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
)
(
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DIGIT_W*N_DIGITS-1:0] i_data,
  input  logic                        i_load,
  input  logic [N_DIGITS-1:0]         i_dp,
  input  logic [N_DIGITS-1:0]         i_blank,
  input  logic [N_DIGITS-1:0]         i_blink,
  input  logic                        i_lzb_en,
  output logic [6:0]                  o_digital,
  output logic                        o_dp,
  output logic [N_DIGITS-1:0]         o_an,
  output logic                        o_frame
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGIT_W*N_DIGITS-1:0] r_data;
  logic [N_DIGITS-1:0]         r_dpSh;
  logic [N_DIGITS-1:0]         r_blankSh;
  logic [N_DIGITS-1:0]         r_blinkSh;

  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [BLK_W-1:0]   r_blinkCnt;
  logic               r_blinkOn;
  logic [DIGIT_W-1:0] r_slotNib;
  logic               r_slotDp;
  logic               r_slotBlank;
  logic               r_slotBlink;
  logic               r_slotZeroAbove;

  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;
  logic                r_dpOut;
  logic                r_frame;

  logic               w_wrap;
  logic               w_frameWrap;
  logic [IDX_W-1:0]   w_nextIdx;
  logic [DIGIT_W-1:0] w_capNib;
  logic               w_capDp;
  logic               w_capBlank;
  logic               w_capBlink;
  logic               w_capZeroAbove;
  logic [6:0]         w_litSeg;
  logic               w_dark;
  logic [N_DIGITS-1:0] w_anNext;
  logic [6:0]          w_segNext;
  logic                w_dpNext;

  assign w_wrap      = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_nextIdx   = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_frameWrap = w_wrap && (w_nextIdx == '0);

  // Pick the shadow fields of the digit about to be scanned; latched once per slot.
  always_comb begin
    w_capNib       = '0;
    w_capDp        = 1'b0;
    w_capBlank     = 1'b0;
    w_capBlink     = 1'b0;
    w_capZeroAbove = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == w_nextIdx) begin
        w_capNib       = r_data[DIGIT_W*k +: DIGIT_W];
        w_capDp        = r_dpSh[k];
        w_capBlank     = r_blankSh[k];
        w_capBlink     = r_blinkSh[k];
        w_capZeroAbove = ((r_data >> (DIGIT_W * k)) == '0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_dpSh    <= '0;
      r_blankSh <= '0;
      r_blinkSh <= '0;
    end else if (i_load) begin
      r_data    <= i_data;
      r_dpSh    <= i_dp;
      r_blankSh <= i_blank;
      r_blinkSh <= i_blink;
    end
  end

  // Slot fields are captured from the pre-load shadow, so a load on the wrap edge lands one slot later.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt           <= '0;
      r_idx           <= '0;
      r_blinkCnt      <= '0;
      r_blinkOn       <= 1'b1;
      r_slotNib       <= '0;
      r_slotDp        <= 1'b0;
      r_slotBlank     <= 1'b0;
      r_slotBlink     <= 1'b0;
      r_slotZeroAbove <= 1'b1;
    end else if (w_wrap) begin
      r_cnt           <= '0;
      r_idx           <= w_nextIdx;
      r_slotNib       <= w_capNib;
      r_slotDp        <= w_capDp;
      r_slotBlank     <= w_capBlank;
      r_slotBlink     <= w_capBlink;
      r_slotZeroAbove <= w_capZeroAbove;
      if (w_frameWrap) begin
        if (r_blinkCnt == BLK_W'(BLINK_FRAMES - 1)) begin
          r_blinkCnt <= '0;
          r_blinkOn  <= ~r_blinkOn;
        end else begin
          r_blinkCnt <= r_blinkCnt + BLK_W'(1);
        end
      end
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  seg7_hex_decode u_decode (
    .i_nibble (r_slotNib),
    .o_seg    (w_litSeg)
  );

  always_comb begin
    w_dark    = r_slotBlank
              | (r_slotBlink & ~r_blinkOn)
              | (i_lzb_en & (r_idx != '0) & r_slotZeroAbove);
    w_anNext  = '0;
    w_segNext = '0;
    w_dpNext  = 1'b0;
    if (r_cnt >= CNT_W'(GUARD)) begin
      w_anNext = N_DIGITS'(1) << r_idx;
      if (!w_dark) begin
        w_segNext = w_litSeg;
        w_dpNext  = r_slotDp;
      end
    end
  end

  // Polarity is folded in only here; everything upstream is active-high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_an    <= {N_DIGITS{AN_ACTIVE_LOW}};
      r_seg   <= {7{SEG_ACTIVE_LOW}};
      r_dpOut <= SEG_ACTIVE_LOW;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_anNext ^ {N_DIGITS{AN_ACTIVE_LOW}};
      r_seg   <= w_segNext ^ {7{SEG_ACTIVE_LOW}};
      r_dpOut <= w_dpNext ^ SEG_ACTIVE_LOW;
      r_frame <= w_frameWrap;
    end
  end

  assign o_an      = r_an;
  assign o_digital = r_seg;
  assign o_dp      = r_dpOut;
  assign o_frame   = r_frame;

endmodule
